// File: rtl/jzjpcc_pkg.sv
// Shared types for the jzjpcc memory stage.
// memOp encodings, FSM states, wait-counter width and lane helpers.
package jzjpcc_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  localparam int CNT_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic logic is_aligned(
    input logic [2:0] op,
    input logic [1:0] a
  );
    logic ok;
    case (op)
      MEM_B, MEM_BU: ok = 1'b1;
      MEM_H, MEM_HU: ok = ~a[0];
      MEM_W:         ok = (a == 2'b00);
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_en(
    input logic [2:0] op,
    input logic [1:0] a
  );
    logic [3:0] be;
    case (op)
      MEM_B, MEM_BU: be = 4'b0001 << a;
      MEM_H, MEM_HU: be = 4'b0011 << a;
      default:       be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_data(
    input logic [2:0]  op,
    input logic [31:0] d
  );
    logic [31:0] r;
    case (op)
      MEM_B, MEM_BU: r = {4{d[7:0]}};
      MEM_H, MEM_HU: r = {2{d[15:0]}};
      default:       r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jzjpcc_load_align.sv
// Load lane extraction: picks byte/half from the read word and extends it.
// Ports: i_rdata, i_addr (byte offset), i_memOp -> o_result.
module jzjpcc_load_align
  import jzjpcc_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_memOp,
  output logic [31:0] o_result
);

  logic [31:0] w_sh;

  assign w_sh = i_rdata >> {i_addr, 3'b000};

  always_comb begin
    o_result = i_rdata;
    case (i_memOp)
      MEM_B:  o_result = {{24{w_sh[7]}}, w_sh[7:0]};
      MEM_H:  o_result = {{16{w_sh[15]}}, w_sh[15:0]};
      MEM_BU: o_result = {24'h0, w_sh[7:0]};
      MEM_HU: o_result = {16'h0, w_sh[15:0]};
      default: o_result = i_rdata;
    endcase
  end

endmodule

// File: rtl/jzjpcc_memory_stage.sv
// Memory stage: one data-bus transaction per load/store with timeout.
// Ports: *_execute inputs, dmem* bus, stall_memory, *_memory writeback/faults.
module jzjpcc_memory_stage
  import jzjpcc_pkg::*;
#(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        memLoad_execute,
  input  logic        memStore_execute,
  input  logic [2:0]  memOp_execute,
  input  logic [31:0] aluResult_execute,
  input  logic [31:0] rs2Data_execute,
  input  logic [4:0]  rdAddr_execute,
  input  logic        regWrite_execute,
  output logic        dmemReq,
  output logic        dmemWe,
  output logic [29:0] dmemAddr,
  output logic [3:0]  dmemByteEnable,
  output logic [31:0] dmemWData,
  input  logic [31:0] dmemRData,
  input  logic        dmemAck,
  output logic        stall_memory,
  output logic [31:0] rdData_memory,
  output logic [4:0]  rdAddr_memory,
  output logic        regWrite_memory,
  output logic        misaligned_memory,
  output logic        busError_memory
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(BUS_TIMEOUT - 1);

  state_e r_state;
  state_e w_next;

  logic [CNT_W-1:0] r_cnt;
  logic [29:0]      r_addr;
  logic [1:0]       r_lane;
  logic [3:0]       r_be;
  logic [31:0]      r_wdata;
  logic [2:0]       r_op;
  logic [4:0]       r_rd;
  logic             r_regw;
  logic             r_store;

  logic [31:0] r_rdData;
  logic [4:0]  r_rdAddr;
  logic        r_regWrite;
  logic        r_mis;
  logic        r_berr;

  logic        w_memop;
  logic        w_aligned;
  logic        w_busy;
  logic        w_timeout;
  logic        w_stall;
  logic [31:0] w_ld;

  assign w_memop   = memLoad_execute | memStore_execute;
  assign w_aligned = is_aligned(memOp_execute, aluResult_execute[1:0]);
  assign w_busy    = (r_state == ST_BUSY);
  // Ack in the final wait cycle takes priority over the timeout.
  assign w_timeout = w_busy & ~dmemAck & (r_cnt == TMO_LAST);

  jzjpcc_load_align u_align (
    .i_rdata  (dmemRData),
    .i_addr   (r_lane),
    .i_memOp  (r_op),
    .o_result (w_ld)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_memop && w_aligned) begin
          w_next  = ST_BUSY;
          w_stall = 1'b1;
        end
      end
      ST_BUSY: begin
        if (dmemAck || w_timeout) w_next = ST_IDLE;
        else                      w_stall = 1'b1;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_addr     <= '0;
      r_lane     <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_op       <= '0;
      r_rd       <= '0;
      r_regw     <= 1'b0;
      r_store    <= 1'b0;
      r_rdData   <= '0;
      r_rdAddr   <= '0;
      r_regWrite <= 1'b0;
      r_mis      <= 1'b0;
      r_berr     <= 1'b0;
    end else begin
      r_mis  <= 1'b0;
      r_berr <= 1'b0;
      if (!w_busy) begin
        if (!w_memop) begin
          r_rdData   <= aluResult_execute;
          r_rdAddr   <= rdAddr_execute;
          r_regWrite <= regWrite_execute;
        end else if (w_aligned) begin
          r_cnt      <= '0;
          r_addr     <= aluResult_execute[31:2];
          r_lane     <= aluResult_execute[1:0];
          r_be       <= byte_en(memOp_execute,
                                aluResult_execute[1:0]);
          r_wdata    <= lane_data(memOp_execute,
                                  rs2Data_execute);
          r_op       <= memOp_execute;
          r_rd       <= rdAddr_execute;
          r_regw     <= regWrite_execute;
          r_store    <= memStore_execute;
          r_regWrite <= 1'b0;
        end else begin
          r_mis      <= 1'b1;
          r_regWrite <= 1'b0;
        end
      end else if (dmemAck) begin
        if (!r_store) begin
          r_rdData   <= w_ld;
          r_rdAddr   <= r_rd;
          r_regWrite <= r_regw;
        end else begin
          r_regWrite <= 1'b0;
        end
      end else if (w_timeout) begin
        r_berr     <= 1'b1;
        r_regWrite <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign dmemReq           = w_busy;
  assign dmemWe            = w_busy & r_store;
  assign dmemAddr          = r_addr;
  assign dmemByteEnable    = r_be;
  assign dmemWData         = r_wdata;
  assign stall_memory      = w_stall;
  assign rdData_memory     = r_rdData;
  assign rdAddr_memory     = r_rdAddr;
  assign regWrite_memory   = r_regWrite;
  assign misaligned_memory = r_mis;
  assign busError_memory   = r_berr;

endmodule

// File: tb/tb_jzjpcc_memory_stage.sv
// Self-checking bench for jzjpcc_memory_stage (BUS_TIMEOUT = 4).
// Directed cases then random ops against a transaction-level model.
module tb_jzjpcc_memory_stage;

  localparam int TMO = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        memLoad_execute, memStore_execute;
  logic [2:0]  memOp_execute;
  logic [31:0] aluResult_execute, rs2Data_execute;
  logic [4:0]  rdAddr_execute;
  logic        regWrite_execute;
  logic        dmemReq, dmemWe;
  logic [29:0] dmemAddr;
  logic [3:0]  dmemByteEnable;
  logic [31:0] dmemWData, dmemRData;
  logic        dmemAck;
  logic        stall_memory;
  logic [31:0] rdData_memory;
  logic [4:0]  rdAddr_memory;
  logic        regWrite_memory, misaligned_memory, busError_memory;

  int n_cmp = 0;
  int n_err = 0;

  jzjpcc_memory_stage #(.BUS_TIMEOUT(TMO)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .memLoad_execute   (memLoad_execute),
    .memStore_execute  (memStore_execute),
    .memOp_execute     (memOp_execute),
    .aluResult_execute (aluResult_execute),
    .rs2Data_execute   (rs2Data_execute),
    .rdAddr_execute    (rdAddr_execute),
    .regWrite_execute  (regWrite_execute),
    .dmemReq           (dmemReq),
    .dmemWe            (dmemWe),
    .dmemAddr          (dmemAddr),
    .dmemByteEnable    (dmemByteEnable),
    .dmemWData         (dmemWData),
    .dmemRData         (dmemRData),
    .dmemAck           (dmemAck),
    .stall_memory      (stall_memory),
    .rdData_memory     (rdData_memory),
    .rdAddr_memory     (rdAddr_memory),
    .regWrite_memory   (regWrite_memory),
    .misaligned_memory (misaligned_memory),
    .busError_memory   (busError_memory)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic go_nop();
    memLoad_execute   = 1'b0;
    memStore_execute  = 1'b0;
    regWrite_execute  = 1'b0;
    aluResult_execute = '0;
  endtask

  // Called at posedge+1; returns at posedge+1.
  // ack_dly: BUSY cycle index (0-based) carrying ack; >= TMO means none.
  task automatic run_op(input bit ld, input bit st, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] rs2,
                        input logic [4:0] rd, input bit rw,
                        input int ack_dly, input logic [31:0] rdat);
    int sz;
    int lane;
    bit valid, aligned, done;
    logic [31:0] e_be, e_wd, e_ld, v;
    lane  = int'(addr % 4);
    valid = 1'b1;
    case (op)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default: begin sz = 4; valid = 1'b0; end
    endcase
    aligned = valid && (addr % sz == 0);
    e_be = (sz == 1) ? (32'd1 << lane) :
           (sz == 2) ? (32'd3 << lane) : 32'd15;
    e_wd = (sz == 1) ? (rs2 & 32'hFF) * 32'h0101_0101 :
           (sz == 2) ? (rs2 & 32'hFFFF) * 32'h0001_0001 : rs2;
    v = rdat >> (8 * lane);
    if (sz == 1) begin
      v = v & 32'hFF;
      if (op == 3'd0 && v >= 32'd128) v = v - 32'd256;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (op == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
    end
    e_ld = v;

    memLoad_execute   = ld;
    memStore_execute  = st;
    memOp_execute     = op;
    aluResult_execute = addr;
    rs2Data_execute   = rs2;
    rdAddr_execute    = rd;
    regWrite_execute  = rw;
    dmemRData         = $urandom;
    dmemAck           = 1'($urandom % 2);

    if (!(ld || st)) begin
      @(negedge clock);
      chk("nop_stall", stall_memory, 0);
      chk("nop_req", dmemReq, 0);
      @(posedge clock); #1;
      chk("nop_rdData", rdData_memory, addr);
      chk("nop_rdAddr", rdAddr_memory, rd);
      chk("nop_regWrite", regWrite_memory, rw);
      chk("nop_faults", {misaligned_memory, busError_memory}, 0);
      dmemAck = 1'b0;
    end else if (!aligned) begin
      @(negedge clock);
      chk("mis_stall", stall_memory, 0);
      chk("mis_req", dmemReq, 0);
      @(posedge clock); #1;
      go_nop();
      dmemAck = 1'b0;
      chk("mis_pulse", misaligned_memory, 1);
      chk("mis_regWrite", regWrite_memory, 0);
      chk("mis_req_after", dmemReq, 0);
      @(posedge clock); #1;
      chk("mis_pulse_end", misaligned_memory, 0);
    end else begin
      dmemAck = 1'b0;
      @(negedge clock);
      chk("cap_stall", stall_memory, 1);
      chk("cap_req", dmemReq, 0);
      @(posedge clock); #1;
      chk("busy_req", dmemReq, 1);
      chk("busy_we", dmemWe, st);
      chk("busy_addr", dmemAddr, addr >> 2);
      chk("busy_be", dmemByteEnable, e_be);
      chk("busy_regWrite", regWrite_memory, 0);
      if (st) chk("busy_wdata", dmemWData, e_wd);
      done = 1'b0;
      for (int k = 0; k < TMO && !done; k++) begin
        if (k == ack_dly) begin
          dmemAck   = 1'b1;
          dmemRData = rdat;
          @(negedge clock);
          chk("ack_stall", stall_memory, 0);
          @(posedge clock); #1;
          dmemAck = 1'b0;
          go_nop();
          chk("ack_req_drop", dmemReq, 0);
          chk("ack_berr", busError_memory, 0);
          if (ld) begin
            chk("ld_data", rdData_memory, e_ld);
            chk("ld_rdAddr", rdAddr_memory, rd);
            chk("ld_regWrite", regWrite_memory, rw);
          end else begin
            chk("st_regWrite", regWrite_memory, 0);
          end
          done = 1'b1;
        end else if (k == TMO - 1) begin
          @(negedge clock);
          chk("tmo_stall", stall_memory, 0);
          chk("tmo_req", dmemReq, 1);
          @(posedge clock); #1;
          go_nop();
          chk("tmo_berr", busError_memory, 1);
          chk("tmo_regWrite", regWrite_memory, 0);
          chk("tmo_req_drop", dmemReq, 0);
          @(posedge clock); #1;
          chk("tmo_berr_end", busError_memory, 0);
          done = 1'b1;
        end else begin
          dmemRData = $urandom;
          @(negedge clock);
          chk("wait_stall", stall_memory, 1);
          chk("wait_req", dmemReq, 1);
          @(posedge clock); #1;
        end
      end
    end
  endtask

  logic [2:0] ld_ops [8] = '{3'd0, 3'd1, 3'd2, 3'd4,
                             3'd5, 3'd3, 3'd6, 3'd7};
  logic [2:0] st_ops [4] = '{3'd0, 3'd1, 3'd2, 3'd3};

  initial begin
    reset_n = 1'b0;
    dmemAck = 1'b0;
    dmemRData = '0;
    memOp_execute = '0;
    rs2Data_execute = '0;
    rdAddr_execute = '0;
    go_nop();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_req", dmemReq, 0);
    chk("rst_stall", stall_memory, 0);
    chk("rst_rdData", rdData_memory, 0);
    chk("rst_outs", {rdAddr_memory, regWrite_memory,
                     misaligned_memory, busError_memory}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;

    run_op(0, 0, 3'd0, 32'hDEAD_BEEF, 0, 5'd5, 1, 0, 0);
    run_op(1, 0, 3'd0, 32'h0000_1003, 0, 5'd9, 1, 0, 32'h80FF_FF7F);
    run_op(0, 1, 3'd1, 32'h0000_2002, 32'h1234_ABCD, 5'd3, 1, 0, 0);
    run_op(1, 0, 3'd2, 32'h0000_0006, 0, 5'd4, 1, 0, 0);
    run_op(1, 0, 3'd5, 32'h0000_0010, 0, 5'd6, 1, 99, 0);
    run_op(1, 0, 3'd1, 32'h0000_0022, 0, 5'd7, 1, TMO - 1,
           32'h8001_0203);

    memLoad_execute   = 1'b1;
    memOp_execute     = 3'd2;
    aluResult_execute = 32'h100;
    rdAddr_execute    = 5'd7;
    regWrite_execute  = 1'b1;
    @(posedge clock); #1;
    chk("rstbusy_req", dmemReq, 1);
    #2;
    reset_n = 1'b0;
    go_nop();
    #1;
    chk("rstbusy_req_drop", dmemReq, 0);
    chk("rstbusy_rdData", rdData_memory, 0);
    chk("rstbusy_outs", {rdAddr_memory, regWrite_memory,
                         misaligned_memory, busError_memory}, 0);
    dmemAck = 1'b1;
    @(posedge clock); #2;
    reset_n = 1'b1;
    @(negedge clock);
    chk("late_ack_req", dmemReq, 0);
    chk("late_ack_stall", stall_memory, 0);
    @(posedge clock); #1;
    chk("late_ack_regWrite", regWrite_memory, 0);
    chk("late_ack_rdData", rdData_memory, 0);
    dmemAck = 1'b0;

    for (int i = 0; i < 300; i++) begin
      int kind;
      logic [2:0] op;
      kind = int'($urandom % 4);
      op = (kind == 3) ? st_ops[$urandom % 4] : ld_ops[$urandom % 8];
      run_op(kind == 1 || kind == 2, kind == 3, op, $urandom,
             $urandom, 5'($urandom), 1'($urandom),
             int'($urandom_range(0, TMO)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jzjpcc_memory_stage.md
JZJPCC_MEMORY_STAGE -- requirements
Module: jzjpcc_memory_stage

Interface
REQ-001 Parameter: BUS_TIMEOUT, 255, max cycles BUSY may wait for dmemAck before aborting (1..255).
REQ-002 clock  in  1  sole clock, all state on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 memLoad_execute / memStore_execute  in  1 each  load / store request; never both high.
REQ-005 memOp_execute  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-006 aluResult_execute  in  32  ALU output: effective address for loads/stores, writeback value otherwise.
REQ-007 rs2Data_execute  in  32  store data.
REQ-008 rdAddr_execute  in  5; regWrite_execute  in  1  destination register and write flag.
REQ-009 dmemReq, dmemWe  out  1  bus request / write strobe.
REQ-010 dmemAddr  out  30  word address (byte address [31:2]).
REQ-011 dmemByteEnable  out  4; dmemWData  out  32; dmemRData  in  32; dmemAck  in  1.
REQ-012 stall_memory  out  1  combinational; upstream holds all *_execute inputs stable while high.
REQ-013 rdData_memory  out  32; rdAddr_memory  out  5; regWrite_memory  out  1  registered writeback.
REQ-014 misaligned_memory, busError_memory  out  1  registered one-cycle fault pulses.

Function
REQ-015 FSM states IDLE, BUSY; reset state IDLE.
REQ-016 Aligned = B any address; H/HU addr[0]=0; W addr[1:0]=00; invalid memOp counts as misaligned.
REQ-017 IDLE, no memory op: next edge rdData_memory<=aluResult_execute, rdAddr/regWrite copied, fault outputs 0; stall_memory=0.
REQ-018 IDLE, aligned load/store: capture address, byte enables, lane data, memOp, rd into registers, go BUSY; stall_memory=1 that cycle; regWrite_memory<=0.
REQ-019 IDLE, misaligned op: no bus request, misaligned_memory<=1 for one cycle, regWrite_memory<=0, stay IDLE, stall_memory=0.
REQ-020 BUSY: dmemReq=1, outputs driven from capture registers; dmemWe=1 for stores; stall_memory = !dmemAck.
REQ-021 Byte enables: B 0001<<addr[1:0]; H 0011<<addr[1:0]; W 1111; loads use the same enables.
REQ-022 dmemWData: B byte replicated to all 4 lanes, H halfword replicated to both halves, W unchanged.
REQ-023 BUSY & dmemAck: go IDLE; load -> rdData_memory<=extracted lane, sign-extended (B,H) or zero-extended (BU,HU), regWrite_memory<=captured regWrite; store -> regWrite_memory<=0.
REQ-024 Minimum load latency: op in cycle 0, dmemReq cycle 1, ack cycle 1, rdData_memory valid cycle 2.
REQ-025 dmemAck outside BUSY SHALL be ignored.
REQ-026 8-bit wait counter cleared on IDLE->BUSY, increments each BUSY cycle without ack; reaching BUS_TIMEOUT -> busError_memory<=1 one cycle, regWrite_memory<=0, go IDLE, stall_memory=0 that cycle.
REQ-027 Ack and timeout in the same cycle: ack wins, no busError.

Reset
REQ-028 reset_n low: state IDLE, counter 0, all registered outputs 0; dmemReq drops immediately, even mid-transaction.
REQ-029 A transaction interrupted by reset SHALL NOT be retried or produce writeback.

Structure
REQ-030 memOp encodings, FSM state enum and timeout counter width live in shared package jzjpcc_pkg.
REQ-031 Load lane extraction/extension SHALL be sub-module jzjpcc_load_align (combinational: rdata, addr[1:0], memOp -> 32-bit result).

Verification
REQ-032 LB addr 0x0000_1003, dmemRData 0x80FF_FF7F, ack after 1 cycle -> byteEnable 1000, rdData_memory 0xFFFF_FF80, stall exactly 1 cycle.
REQ-033 SH addr 0x0000_2002, rs2 0x1234_ABCD -> byteEnable 1100, dmemWData 0xABCD_ABCD, dmemWe 1, regWrite_memory 0.
REQ-034 LW addr 0x0000_0006 -> no dmemReq, misaligned_memory one-cycle pulse, regWrite_memory 0.
REQ-035 LHU addr 0x10, ack withheld, BUS_TIMEOUT 4 -> busError_memory pulse after 4 BUSY cycles, stall released, FSM IDLE.
REQ-036 reset_n asserted in BUSY before ack -> dmemReq 0 immediately, outputs 0, late ack ignored.
REQ-037 Non-memory op, aluResult 0xDEAD_BEEF, rd 5, regWrite 1 -> next cycle rdData_memory 0xDEAD_BEEF, rdAddr_memory 5, no stall.
